// File: rtl/syn_fifo_burst_reader_pkg.sv
// Shared definitions for the syn_fifo burst reader: FSM state encoding.
package syn_fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/syn_fifo_burst_reader_skid_buf.sv
// In-order register FIFO that absorbs words returning from the syn_fifo read port.
module syn_fifo_burst_reader_skid_buf #(
  parameter int data_width = 8,
  parameter int buf_depth  = 3,
  localparam int cnt_width = $clog2(buf_depth + 1),
  localparam int ptr_width = (buf_depth > 1) ? $clog2(buf_depth) : 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic [cnt_width-1:0]  count
);

  typedef logic [ptr_width-1:0] ptr_t;
  typedef logic [cnt_width-1:0] cnt_t;

  logic [data_width-1:0] mem_q [buf_depth];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(buf_depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < buf_depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/syn_fifo_burst_reader.sv
// Pops burst_len words from a syn_fifo (1-cycle read latency) and streams them out
// as valid/ready with a last marker; reads are credit-limited by the output buffer.
module syn_fifo_burst_reader
  import syn_fifo_burst_reader_pkg::*;
#(
  parameter int data_width = 8,
  parameter int len_width  = 8,
  parameter int buf_depth  = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [len_width-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_r_en,
  input  logic [data_width-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  m_last
);

  localparam int cnt_width = $clog2(buf_depth + 1);
  typedef logic [cnt_width-1:0] cnt_t;
  typedef logic [cnt_width:0]   cred_t;
  typedef logic [len_width-1:0] len_t;

  rd_state_e state_q, state_d;
  len_t      rd_rem_q, rd_rem_d;
  len_t      out_rem_q, out_rem_d;
  cnt_t      inflight_q;
  cnt_t      count;
  logic      done_q, done_d;
  logic      handshake;
  cred_t     credit_used;

  syn_fifo_burst_reader_skid_buf #(
    .data_width(data_width),
    .buf_depth (buf_depth)
  ) u_skid_buf (
    .clk      (clk),
    .clr      (clr),
    .push     (inflight_q != '0),
    .push_data(fifo_data_out),
    .pop      (handshake),
    .head     (m_data),
    .count    (count)
  );

  // A read is only issued when the buffer has room for it and everything already in flight,
  // so the pop strobe never depends on m_ready.
  assign credit_used = cred_t'(count) + cred_t'(inflight_q);
  assign fifo_r_en   = (state_q == READ) && !fifo_empty && (credit_used < cred_t'(buf_depth));

  assign m_valid   = (count != '0);
  assign handshake = m_valid && m_ready;
  assign m_last    = m_valid && (out_rem_q == len_t'(1));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            rd_rem_d  = burst_len;
            out_rem_d = burst_len;
            state_d   = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (fifo_r_en) begin
          rd_rem_d = rd_rem_q - len_t'(1);
          if (rd_rem_q == len_t'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (handshake && (out_rem_q == len_t'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The buffer is always empty in IDLE, so this never collides with the load above.
    if (handshake) begin
      out_rem_d = out_rem_q - len_t'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      rd_rem_q   <= '0;
      out_rem_q  <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_rem_q   <= rd_rem_d;
      out_rem_q  <= out_rem_d;
      inflight_q <= cnt_t'(fifo_r_en);
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_syn_fifo_burst_reader.sv
// Directed bench for syn_fifo_burst_reader with a behavioural syn_fifo and a scoreboard monitor.
`timescale 1ns/1ps
module tb_syn_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int BD = 3;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, fifo_r_en;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] pend_q[$];

  logic [DW-1:0] fmem [0:255];
  int            wr_p = 0;
  int            rd_p = 0;
  logic          fifo_flush = 1'b0;

  int            done_cnt  = 0;
  int            hs_total  = 0;
  int            rd_issued = 0;
  int            hs_pop    = 0;
  logic          stall_q   = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always #5 clk = ~clk;

  syn_fifo_burst_reader #(
    .data_width(DW),
    .len_width (LW),
    .buf_depth (BD)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .fifo_r_en    (fifo_r_en),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  // Behavioural syn_fifo: registered read data one cycle after r_en.
  assign fifo_empty = (wr_p == rd_p);
  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_p <= wr_p;
    end else if (fifo_r_en) begin
      fifo_data_out <= fmem[rd_p & 255];
      rd_p          <= rd_p + 1;
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, read-strobe legality.
  always @(negedge clk) begin
    if (clr) begin
      stall_q   = 1'b0;
      rd_issued = 0;
      hs_pop    = 0;
    end else begin
      if (done) done_cnt++;
      if (fifo_r_en) begin
        total++;
        if (fifo_empty || !busy || ((rd_issued - hs_pop) >= BD)) begin
          bad++;
          $display("FAIL read_strobe: r_en=1 empty=%0d busy=%0d outstanding=%0d required outstanding<%0d non-empty busy",
                   fifo_empty, busy, rd_issued - hs_pop, BD);
        end
      end
      if (stall_q) begin
        total++;
        if (!m_valid || (m_data != stall_data)) begin
          bad++;
          $display("FAIL stall_hold: valid=%0d data=%0h required valid=1 data=%0h", m_valid, m_data, stall_data);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: got data=%0h last=%0d required no beat", m_data, m_last);
        end else begin
          mon_e = exp_q.pop_front();
          if ((m_data != mon_e.data) || (m_last != mon_e.last)) begin
            bad++;
            $display("FAIL beat: got data=%0h last=%0d required data=%0h last=%0d",
                     m_data, m_last, mon_e.data, mon_e.last);
          end else begin
            $display("beat data=%0h last=%0d ok", m_data, m_last);
          end
        end
        hs_total++;
        hs_pop++;
      end
      if (fifo_r_en) rd_issued++;
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [DW-1:0] v);
    fmem[wr_p & 255] = v;
    wr_p++;
  endtask

  task automatic exp_push(input logic [DW-1:0] v, input logic l);
    exp_t e;
    e.data = v;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic issue_start(input logic [LW-1:0] len);
    start     = 1'b1;
    burst_len = len;
    step();
    start = 1'b0;
  endtask

  // Steps until done is seen; cyc = edges after the start edge, 0 on timeout.
  task automatic run_until_done(input int max_cyc, input bit toggle, input int gap, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (toggle) m_ready = ~m_ready;
      if ((gap != 0) && ((i % gap) == 0) && (pend_q.size() > 0)) fifo_push(pend_q.pop_front());
      if (done) begin
        cyc = i;
        break;
      end
      total++;
      if (!busy) begin
        bad++;
        $display("FAIL busy_during_burst: got busy=0 required 1 at cycle %0d", i);
      end
    end
    total++;
    if (cyc == 0) begin
      bad++;
      $display("FAIL done_timeout: got no done in %0d cycles required done", max_cyc);
    end
    chk("busy_at_done", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int h0;

    // Reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    clr = 1'b0;
    step();

    // 1: full-rate burst of 7
    base = done_cnt;
    for (int v = 1; v <= 7; v++) begin
      fifo_push(DW'(v));
      exp_push(DW'(v), v == 7);
    end
    m_ready = 1'b1;
    issue_start(8'd7);
    chk("s1_busy_after_start", busy, 1);
    run_until_done(50, 1'b0, 0, cyc);
    chk("s1_cycles", cyc, 9);
    step();
    chk("s1_done_pulses", done_cnt - base, 1);
    chk("s1_done_width", done, 0);
    chk("s1_exp_empty", exp_q.size(), 0);

    // 2: stalled consumer
    base = done_cnt;
    for (int v = 1; v <= 7; v++) begin
      fifo_push(DW'(v));
      exp_push(DW'(v), v == 7);
    end
    issue_start(8'd7);
    run_until_done(150, 1'b1, 0, cyc);
    m_ready = 1'b1;
    step();
    chk("s2_done_pulses", done_cnt - base, 1);
    chk("s2_exp_empty", exp_q.size(), 0);

    // 3: slow writer into an empty FIFO
    base = done_cnt;
    pend_q.push_back(8'hA);
    pend_q.push_back(8'hB);
    pend_q.push_back(8'hC);
    exp_push(8'hA, 1'b0);
    exp_push(8'hB, 1'b0);
    exp_push(8'hC, 1'b1);
    issue_start(8'd3);
    run_until_done(200, 1'b0, 20, cyc);
    chk("s3_cycles", cyc, 63);
    step();
    chk("s3_done_pulses", done_cnt - base, 1);
    chk("s3_exp_empty", exp_q.size(), 0);

    // 4: zero-length burst
    base = done_cnt;
    issue_start(8'd0);
    chk("s4_done", done, 1);
    chk("s4_busy", busy, 0);
    step();
    chk("s4_done_width", done, 0);
    chk("s4_done_pulses", done_cnt - base, 1);

    // 5: clr after 3 of 6 words
    for (int v = 1; v <= 6; v++) begin
      fifo_push(DW'(8'h40 + v));
      exp_push(DW'(8'h40 + v), v == 6);
    end
    h0 = hs_total;
    issue_start(8'd6);
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      if (hs_total >= h0 + 3) begin
        cyc = i;
        break;
      end
      step();
    end
    chk("s5_three_beats_seen", (cyc != 0), 1);
    base = done_cnt;
    clr = 1'b1;
    #1;
    chk("s5_clr_busy", busy, 0);
    chk("s5_clr_r_en", fifo_r_en, 0);
    chk("s5_clr_m_valid", m_valid, 0);
    chk("s5_clr_m_last", m_last, 0);
    chk("s5_clr_m_data", m_data, 0);
    step();
    step();
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    exp_q.delete();
    clr = 1'b0;
    step();
    chk("s5_no_done", done_cnt - base, 0);

    // 5b + 6: fresh burst of 2, then back-to-back burst of 4 started in the done cycle
    base = done_cnt;
    fifo_push(8'h21);
    fifo_push(8'h22);
    exp_push(8'h21, 1'b0);
    exp_push(8'h22, 1'b1);
    for (int v = 1; v <= 4; v++) begin
      fifo_push(DW'(8'h30 + v));
      exp_push(DW'(8'h30 + v), v == 4);
    end
    issue_start(8'd2);
    run_until_done(50, 1'b0, 0, cyc);
    chk("s5_fresh_cycles", cyc, 4);
    start     = 1'b1;
    burst_len = 8'd4;
    step();
    chk("s6_accept_in_done_cycle", busy, 1);
    burst_len = 8'd9;
    step();
    step();
    step();
    start = 1'b0;
    run_until_done(50, 1'b0, 0, cyc);
    chk("s6_cycles", cyc, 3);
    step();
    chk("s6_done_pulses", done_cnt - base, 2);
    chk("s6_exp_empty", exp_q.size(), 0);
    step();
    step();
    chk("s6_idle_busy", busy, 0);
    chk("s6_idle_valid", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
